// File: rtl/fft_stream_core.sv
// fft_stream_core
//   Streaming N-point radix-2 DIT FFT/IFFT (N = 2**LOG2N, 4 or 8) on a
//   single in-place complex buffer. A frame is loaded in natural order and
//   stored at bit-reversed addresses. It is then transformed with one
//   butterfly per enabled cycle and unloaded in natural order. Every
//   butterfly halves its outputs, so the result is X/N.
//
// Parameters
//   DATA_W  signed component width (6..16)
//   LOG2N   log2 of transform size (2 or 3)
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   en                global enable; low freezes all state
//   in_valid/in_ready input handshake, in_real/in_imag sample x[k]
//   inverse           direction, captured on the x[0] beat (1 = inverse)
//   out_valid/out_ready output handshake, out_real/out_imag = X[out_index]
//   busy              high while computing or unloading
//
// Build option
//   FFT_STREAM_ROUND_EN  round half-up on every >>>6 and >>>1. When this
//                        macro is undefined, the shifts truncate.
module fft_stream_core #(
  parameter int DATA_W = 8,
  parameter int LOG2N  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              inverse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [LOG2N-1:0]  out_index,
  output logic              busy
);

  localparam int N  = 1 << LOG2N;
  localparam int HB = N / 2;            // butterflies per stage
  localparam int BW = LOG2N - 1;        // butterfly counter width
  localparam int SW = (LOG2N > 2) ? 2 : 1;
  localparam int IW = DATA_W + 2;       // butterfly sum width
  localparam int PW = DATA_W + 10;      // twiddle product width

`ifdef FFT_STREAM_ROUND_EN
  localparam logic signed [PW-1:0] RND6 = PW'(32);
  localparam logic signed [IW-1:0] RND1 = IW'(1);
`else
  localparam logic signed [PW-1:0] RND6 = '0;
  localparam logic signed [IW-1:0] RND1 = '0;
`endif

  localparam logic signed [IW-1:0] SMAX = IW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [IW-1:0] SMIN = IW'(-(1 << (DATA_W - 1)));

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t             state;
  logic [LOG2N-1:0]   ld_cnt;
  logic [LOG2N-1:0]   out_cnt;
  logic [BW-1:0]      bf_cnt;
  logic [SW-1:0]      stg_cnt;
  logic               inv_q;
  logic               out_valid_q;
  logic               busy_q;

  logic signed [DATA_W-1:0] mem_re [N];
  logic signed [DATA_W-1:0] mem_im [N];

  logic in_acc, do_bf;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [IW-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > SMAX)      r = {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < SMIN) r = {1'b1, {(DATA_W-1){1'b0}}};
    else               r = v[DATA_W-1:0];
    return r;
  endfunction

  assign in_ready  = en && (state == S_LOAD);
  assign in_acc    = in_ready && in_valid;
  assign do_bf     = en && (state == S_COMPUTE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_index = out_cnt;
  assign out_real  = mem_re[out_cnt];
  assign out_imag  = mem_im[out_cnt];

  // Butterfly datapath. Stage s pairs the entries a and b = a + 2**s.
  // The butterfly index j splits into a group part (bits above s), which is
  // shifted up by one to make room for the pair bit, and a position k
  // inside the group. The twiddle exponent is k * N / 2**(s+1).
  logic [LOG2N-1:0]         j_ext, hmask, k_idx, a_idx, b_idx, tw_e;
  logic [2:0]               e8;
  logic signed [7:0]        w_cos, w_sin, w_re, w_im;
  logic signed [PW-1:0]     wr_x, wi_x, br_x, bi_x, p_re, p_im;
  logic signed [IW-1:0]     t_re, t_im, a_re_x, a_im_x;
  logic signed [IW-1:0]     sa_re, sa_im, sb_re, sb_im;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [DATA_W-1:0] na_re, na_im, nb_re, nb_im;

  always_comb begin
    j_ext = LOG2N'(bf_cnt);
    hmask = (LOG2N'(1) << stg_cnt) - LOG2N'(1);
    k_idx = j_ext & hmask;
    a_idx = ((j_ext & ~hmask) << 1) | k_idx;
    b_idx = a_idx | (LOG2N'(1) << stg_cnt);
    tw_e  = k_idx << (LOG2N - 1 - int'(stg_cnt));
    // The ROM holds eighth-circle steps, so N=4 exponents scale by 2.
    e8    = 3'(tw_e) << (3 - LOG2N);

    case (e8)
      3'd1:    begin w_cos = 8'sd45;  w_sin = 8'sd45; end
      3'd2:    begin w_cos = 8'sd0;   w_sin = 8'sd64; end
      3'd3:    begin w_cos = -8'sd45; w_sin = 8'sd45; end
      default: begin w_cos = 8'sd64;  w_sin = 8'sd0;  end
    endcase
    // The forward transform uses cos - j*sin. The inverse transform
    // conjugates the twiddle.
    w_re = w_cos;
    w_im = inv_q ? w_sin : -w_sin;

    a_re = mem_re[a_idx];
    a_im = mem_im[a_idx];
    b_re = mem_re[b_idx];
    b_im = mem_im[b_idx];

    wr_x = PW'(w_re);
    wi_x = PW'(w_im);
    br_x = PW'(b_re);
    bi_x = PW'(b_im);
    p_re = wr_x * br_x - wi_x * bi_x + RND6;
    p_im = wr_x * bi_x + wi_x * br_x + RND6;
    // |W*b| is at most sqrt(2) * full scale, so it fits IW bits after >>>6.
    t_re = IW'(p_re >>> 6);
    t_im = IW'(p_im >>> 6);

    a_re_x = IW'(a_re);
    a_im_x = IW'(a_im);
    sa_re  = (a_re_x + t_re + RND1) >>> 1;
    sa_im  = (a_im_x + t_im + RND1) >>> 1;
    sb_re  = (a_re_x - t_re + RND1) >>> 1;
    sb_im  = (a_im_x - t_im + RND1) >>> 1;
    na_re  = sat(sa_re);
    na_im  = sat(sa_im);
    nb_re  = sat(sb_re);
    nb_im  = sat(sb_im);
  end

  // The buffer is not reset. Stale contents can never reach the output,
  // because out_valid stays low until a complete new frame is computed.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      mem_re[bitrev(ld_cnt)] <= in_real;
      mem_im[bitrev(ld_cnt)] <= in_imag;
    end else if (do_bf) begin
      mem_re[a_idx] <= na_re;
      mem_im[a_idx] <= na_im;
      mem_re[b_idx] <= nb_re;
      mem_im[b_idx] <= nb_im;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_LOAD;
      ld_cnt      <= '0;
      out_cnt     <= '0;
      bf_cnt      <= '0;
      stg_cnt     <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (en) begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            if (ld_cnt == '0) inv_q <= inverse;
            if (ld_cnt == LOG2N'(N - 1)) begin
              ld_cnt <= '0;
              state  <= S_COMPUTE;
              busy_q <= 1'b1;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (bf_cnt == BW'(HB - 1)) begin
            bf_cnt <= '0;
            if (stg_cnt == SW'(LOG2N - 1)) begin
              stg_cnt     <= '0;
              state       <= S_UNLOAD;
              out_valid_q <= 1'b1;
            end else begin
              stg_cnt <= stg_cnt + 1'b1;
            end
          end else begin
            bf_cnt <= bf_cnt + 1'b1;
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            if (out_cnt == LOG2N'(N - 1)) begin
              out_cnt     <= '0;
              state       <= S_LOAD;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: doc/fft_stream_core.md
FFT_STREAM_CORE -- requirements
Module: fft_stream_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8; signed two's-complement width of each real/imag component, legal 6..16.
REQ-002 SHALL have parameter LOG2N, default 2; transform size N = 2**LOG2N, legal 2 (N=4) or 3 (N=8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  global enable; when low, all state, counters and outputs hold.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_real input DATA_W, in_imag input DATA_W  sample input stream, natural order x[0..N-1].
REQ-007 SHALL have port inverse  input  1  transform direction, sampled on the accepted x[0] beat: 0 = forward, 1 = inverse (conjugate twiddles).
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_real output DATA_W, out_imag output DATA_W, out_index output LOG2N  result stream, natural order X[0..N-1].
REQ-009 SHALL have port busy  output  1  high in COMPUTE or UNLOAD.

Function
REQ-010 SHALL run a three-state FSM: LOAD -> COMPUTE after the N-th accepted input beat; COMPUTE -> UNLOAD after the last butterfly; UNLOAD -> LOAD after the N-th accepted output beat.
REQ-011 SHALL assert in_ready = en and state==LOAD; a beat is accepted when in_valid, in_ready and en are all high on a rising edge.
REQ-012 SHALL store accepted beat k at bit-reversed address rev(k) of an N-entry complex buffer.
REQ-013 SHALL execute an in-place iterative radix-2 DIT transform with one butterfly per enabled cycle; COMPUTE lasts exactly (N/2)*LOG2N enabled cycles (4 for N=4, 12 for N=8).
REQ-014 SHALL use twiddles W = cos - j*sin (forward) or cos + j*sin (inverse), coded in Q1.6: 1.0 = 64, 0.7071 = 45.
REQ-015 SHALL compute t = (W*b) >>> 6 with full-precision products, then A = (a + t) >>> 1 and B = (a - t) >>> 1 using DATA_W+2 bit intermediates, saturating A and B to the signed DATA_W range.
REQ-016 Scaling per REQ-015 SHALL divide the final result by N overall; no other scaling applies in either direction.
REQ-017 SHALL assert out_valid = state==UNLOAD, presenting X[out_index] combinationally from the buffer; out_index increments only on an accepted output beat (out_valid, out_ready, en).
REQ-018 While out_valid is high and out_ready is low, out_real, out_imag and out_index SHALL hold stable.
REQ-019 The first out_valid SHALL assert on the cycle after the final COMPUTE cycle; the minimum frame period is N + (N/2)*LOG2N + N cycles.
REQ-020 in_valid during COMPUTE or UNLOAD SHALL be ignored (in_ready low); no sample is lost or overwritten.
REQ-021 The inverse value SHALL be held for the whole frame; changes after the x[0] beat SHALL NOT affect it.

Reset
REQ-022 On rst high, asynchronously: state = LOAD, load/butterfly/output counters = 0, inverse latch = 0, busy = 0, out_valid = 0, out_index = 0; in_ready follows en.
REQ-023 Buffer contents SHALL NOT be required to reset; no stale data is observable, since out_valid is low until a full new frame is computed.
REQ-024 rst asserted mid-LOAD, mid-COMPUTE or mid-UNLOAD SHALL abort the frame; the next accepted beat is x[0].

Configuration
REQ-025 With macro FFT_STREAM_ROUND_EN defined, each >>> 1 and >>> 6 in REQ-015 SHALL round half-up: add 1 or 32 respectively before shifting.
REQ-026 Without FFT_STREAM_ROUND_EN, all shifts SHALL truncate (arithmetic shift, toward minus infinity).

Verification
REQ-027 Impulse (N=4, DATA_W=8): x = {64,0,0,0}, forward -> all four X = 16 + j0, out_index 0,1,2,3.
REQ-028 Alternating input: x = {32,-32,32,-32} -> X[2] = 32 + j0; X[0], X[1], X[3] = 0; out_valid exactly 4 cycles after the last input beat.
REQ-029 Inverse mode: x = {0,64,0,0}, inverse=1 -> X = {16, j16, -16, -j16}; the same input with inverse=0 -> {16, -j16, -16, j16}.
REQ-030 Backpressure: hold out_ready low for 5 cycles during X[1] -> X[1] and out_index=1 stable; in_ready stays 0; no output beat is skipped.
REQ-031 Reset mid-COMPUTE: pulse rst during cycle 2 of COMPUTE -> out_valid=0, busy=0, in_ready=1 next cycle; the following frame computes correctly.
REQ-032 Rounding: x = {1,0,0,0} -> all X = 0 without FFT_STREAM_ROUND_EN, all X = 1 with it; N=8 DC input 16 on all samples -> X[0]=16, others 0.
